// File: rtl/read_request_sequencer.sv
// Read request sequencer: issues num_requests read requests over a region in
// sequential/stride or LFSR-random order, limits outstanding requests to
// MAX_OUT, tracks completions and reports run statistics.
module read_request_sequencer #(
  parameter int unsigned MAX_OUT   = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ap_start,
  input  logic [63:0] num_requests,
  input  logic [63:0] base_addr,
  input  logic [63:0] bound,
  input  logic [63:0] req_size,
  input  logic [63:0] stride,
  input  logic        access_pattern,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic [31:0] req_len,
  input  logic        rsp_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] issued_cnt,
  output logic [63:0] completed_cnt,
  output logic [63:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_n;
  logic        start_q;
  logic [63:0] num_q, base_q, bound_q, stride_q;
  logic        rand_q;

  logic [8:0]  outstanding, out_n;
  logic [31:0] lfsr, lfsr_n;
  logic [63:0] offset, offset_n, seq_sum;
  logic [63:0] issued_n, completed_n, cycle_n, addr_n;
  logic [31:0] len_n;
  logic        valid_n, err_n;
  logic        capture, hs, active, rsp_ok, rsp_bad;

  // Only the low word of req_size reaches the request channel.
  logic unused_size_hi;
  assign unused_size_hi = ^req_size[63:32];

  // Galois LFSR, x^32 + x^22 + x^2 + x + 1 in right-shift form.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Random-mode offset: LFSR value masked to the power-of-two region, 64-byte aligned.
  function automatic logic [63:0] rand_off(input logic [31:0] v, input logic [63:0] b);
    return {32'b0, v} & (b - 64'd1) & ~64'h3F;
  endfunction

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  // Next state, counters, address generation and request channel next values.
  always_comb begin
    state_n     = state;
    capture     = (state == IDLE) && ap_start && !start_q;
    active      = (state == RUN) || (state == DRAIN);
    hs          = req_valid && req_ready;
    rsp_ok      = active && rsp_valid && (outstanding != '0);
    rsp_bad     = active && rsp_valid && (outstanding == '0);
    seq_sum     = offset + stride_q;
    issued_n    = issued_cnt;
    completed_n = completed_cnt;
    cycle_n     = cycle_cnt;
    out_n       = outstanding;
    err_n       = err;
    lfsr_n      = lfsr;
    offset_n    = offset;
    addr_n      = req_addr;
    len_n       = req_len;
    valid_n     = 1'b0;

    case (state)
      IDLE: begin
        if (capture) begin
          issued_n    = '0;
          completed_n = '0;
          cycle_n     = '0;
          out_n       = '0;
          err_n       = 1'b0;
          lfsr_n      = LFSR_SEED;
          offset_n    = '0;
          len_n       = req_size[31:0];
          addr_n      = access_pattern ? base_addr + rand_off(LFSR_SEED, bound) : base_addr;
          if (num_requests == '0) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            valid_n = 1'b1;
          end
        end
      end
      RUN, DRAIN: begin
        cycle_n     = cycle_cnt + 64'd1;
        issued_n    = issued_cnt + {63'b0, hs};
        completed_n = completed_cnt + {63'b0, rsp_ok};
        out_n       = outstanding + {8'b0, hs} - {8'b0, rsp_ok};
        if (rsp_bad) err_n = 1'b1;
        if (hs) begin
          if (rand_q) begin
            lfsr_n = lfsr_step(lfsr);
            addr_n = base_q + rand_off(lfsr_n, bound_q);
          end else begin
            offset_n = ((bound_q == '0) || (seq_sum >= bound_q)) ? '0 : seq_sum;
            addr_n   = base_q + offset_n;
          end
        end
        if (completed_n == num_q)                          state_n = DONE;
        else if ((state == RUN) && (issued_cnt == num_q))  state_n = DRAIN;
        // Computed from next-cycle counts so a valid request can only drop on its own handshake.
        valid_n = (state_n == RUN) && (issued_n < num_q) && (out_n < 9'(MAX_OUT));
      end
      DONE: begin
        if (!ap_start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Configuration captured on the start edge; later input changes are ignored.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      num_q    <= '0;
      base_q   <= '0;
      bound_q  <= '0;
      stride_q <= '0;
      rand_q   <= 1'b0;
    end else if (capture) begin
      num_q    <= num_requests;
      base_q   <= base_addr;
      bound_q  <= bound;
      stride_q <= stride;
      rand_q   <= access_pattern;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_q       <= 1'b0;
      outstanding   <= '0;
      lfsr          <= LFSR_SEED;
      offset        <= '0;
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_len       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      issued_cnt    <= '0;
      completed_cnt <= '0;
      cycle_cnt     <= '0;
    end else begin
      start_q       <= ap_start;
      outstanding   <= out_n;
      lfsr          <= lfsr_n;
      offset        <= offset_n;
      req_valid     <= valid_n;
      req_addr      <= addr_n;
      req_len       <= len_n;
      busy          <= (state_n == RUN) || (state_n == DRAIN);
      done          <= (state_n == DONE);
      err           <= err_n;
      issued_cnt    <= issued_n;
      completed_cnt <= completed_n;
      cycle_cnt     <= cycle_n;
    end
  end

endmodule
